// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/addr_ok/data_ok instruction bus
// and fills the F/D pipeline register, handling misaligned PCs, stalls and flushes.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        addr_err_if;
    logic        in_delay_slot;
    logic        is_instr;
  } dp_ftod;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] f_nextpc,
  input  logic        f_indelayslot,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] f_nowpc,
  output logic        if_stall,
  output dp_ftod      ftod
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        dly_q, dly_d;
  logic [31:0] buf_q, buf_d;
  dp_ftod      ftod_q, ftod_d;

  logic misal;
  logic have;
  logic deliver;
  logic owed;

  assign misal     = pc_q[1:0] != 2'b00;
  assign have      = (state_q == S_REQ && misal) || (state_q == S_WAIT && inst_data_ok) ||
                     (state_q == S_HOLD);
  assign if_stall  = !have;
  assign deliver   = have && !stall && !flush;
  assign inst_req  = (state_q == S_REQ) && !misal;
  assign inst_addr = pc_q;
  assign f_nowpc   = pc_q;
  assign ftod      = ftod_q;

  // A bus response is still owed if a request is accepted now or one is in flight without data.
  assign owed = (inst_req && inst_addr_ok) ||
                ((state_q == S_WAIT || state_q == S_DISCARD) && !inst_data_ok);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dly_d   = dly_q;
    buf_d   = buf_q;
    ftod_d  = ftod_q;
    if (flush) begin
      ftod_d  = '0;
      pc_d    = flush_pc;
      dly_d   = 1'b0;
      state_d = owed ? S_DISCARD : S_REQ;
    end else if (deliver) begin
      ftod_d.pc            = pc_q;
      ftod_d.instr         = misal ? 32'h0 : ((state_q == S_HOLD) ? buf_q : inst_rdata);
      ftod_d.addr_err_if   = misal;
      ftod_d.in_delay_slot = dly_q;
      ftod_d.is_instr      = 1'b1;
      pc_d                 = f_nextpc;
      dly_d                = f_indelayslot;
      state_d              = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (inst_req && inst_addr_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            buf_d   = inst_rdata;
            state_d = S_HOLD;
          end
        end
        S_HOLD: state_d = S_HOLD;
        S_DISCARD: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      dly_q   <= 1'b0;
      buf_q   <= 32'h0;
      ftod_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dly_q   <= dly_d;
      buf_q   <= buf_d;
      ftod_q  <= ftod_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of decode. Owns the PC register and drives the instruction SRAM-like bus (req/addr_ok/data_ok handshake). Latches each fetched instruction into the F/D pipeline register `ftod` and consumes the next PC and delay-slot flag that decode computes. Handles misaligned PCs, decode stalls and exception/eret flushes.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC00000: PC after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `f_nextpc`  in  32  next PC from decode.
- `f_indelayslot`  in  1  the instruction at `f_nextpc` sits in a delay slot.
- `stall`  in  1  hazard-unit hold of the F/D register; already includes `if_stall`.
- `flush`  in  1  exception or eret redirect.
- `flush_pc`  in  32  redirect target, 32'hBFC00380 or EPC.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  32  bus address, always equal to `f_nowpc`.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `f_nowpc`  out  32  current PC.
- `if_stall`  out  1  no instruction ready for delivery this cycle.
- `ftod`  out  dp_ftod  F/D register, fields `pc`, `instr`, `addr_err_if`, `in_delay_slot`, `is_instr`.

## Operation
- States: REQ, WAIT, HOLD, DISCARD.
- `misal` = `f_nowpc[1:0] != 0`.
- `have` = (REQ & misal) | (WAIT & `inst_data_ok`) | HOLD.
- `if_stall` = !`have`. It is a combinational function of state and bus inputs only and never depends on `stall`.
- `deliver` = `have` & !`stall` & !`flush`.
- On `deliver`:
  - `ftod` ← {pc=`f_nowpc`, instr=(misal ? 0 : captured or live data), addr_err_if=misal, in_delay_slot=registered delay flag of this PC, is_instr=1}.
  - `f_nowpc` ← `f_nextpc`; delay flag ← `f_indelayslot`; state → REQ.
- REQ:
  - `inst_req` = !misal.
  - `addr_ok` → WAIT.
  - misal: no bus access; instruction is immediately available as an address-error NOP.
- WAIT:
  - `inst_req` = 0.
  - `data_ok` & `stall` → capture `inst_rdata` into a buffer, go to HOLD.
  - `data_ok` & !`stall` → deliver the live data.
- HOLD:
  - `inst_req` = 0.
  - Deliver the buffered word once `stall` is low.
- `flush` (highest priority, overrides `stall`):
  - `ftod.is_instr` ← 0; `addr_err_if` and `in_delay_slot` ← 0.
  - `f_nowpc` ← `flush_pc`; delay flag ← 0.
  - Next state: DISCARD if a response is still owed (WAIT without `data_ok`, or REQ with `addr_ok` this cycle); otherwise REQ.
  - An in-flight `data_ok` in the flush cycle is dropped.
- DISCARD:
  - `inst_req` = 0.
  - `data_ok` → drop data, go to REQ.
- At most one outstanding bus transaction.
- `ftod` holds its value while `stall` is high and no flush occurs.

## Timing
- Reset values:
  - `f_nowpc` = RESET_PC; state REQ; delay flag 0.
  - `ftod` = all zero, `is_instr`=0.
  - `inst_req` = 1 in the first cycle after reset release.
- Latency with zero-wait memory (`addr_ok` in the request cycle, `data_ok` the cycle after): one instruction every 2 cycles. Each instruction appears in `ftod` on the edge ending its `data_ok` cycle.
- Misaligned PC: `ftod` updates on the next edge with no bus traffic.
- Flush takes effect on the edge of the flush cycle. The first `inst_req` to `flush_pc` is issued in the next cycle (REQ) or after the owed `data_ok` (DISCARD).
- Reset mid-transaction returns to REQ at RESET_PC. The bus slave is reset by the same `resetn`.

## Test plan
- Reset, zero-wait memory returning `inst_rdata`=addr^32'h1: `inst_addr` sequence BFC00000, BFC00004, …; each `ftod.pc` and `instr` pair matches; `if_stall` is high only during REQ cycles.
- `data_ok` arrives while `stall` is high for 3 cycles: state is HOLD; `ftod` is unchanged until `stall` falls; the buffered word is delivered on the first cycle with `stall`=0; no second `inst_req` is issued while stalled.
- Decode drives `f_nextpc`=32'hBFC00100 with `f_indelayslot`=1: the next fetch address is BFC00100 and it arrives with `ftod.in_delay_slot`=1.
- `f_nextpc`=32'hBFC00002: no `inst_req`; the next edge gives `ftod`={pc=BFC00002, instr=0, addr_err_if=1, is_instr=1}.
- `flush` with `flush_pc`=BFC00380 one cycle after `addr_ok`, with `data_ok` two cycles later:
  - `ftod.is_instr`=0 on the flush edge.
  - The late data is discarded.
  - The next `inst_addr` is BFC00380.
- `flush` and `stall` asserted together while in HOLD: the flush wins, the buffer is dropped, and the next request goes to `flush_pc`.
